// File: rtl/simple_multi_fifo.sv
// simple_multi_fifo: CHANNELS independent FIFOs sharing one memory array, per-channel pointers/counts/flags.
// Define SIMPLE_MULTI_FIFO_OVF_CNT_EN to build the per-channel saturating overflow counters.
module simple_multi_fifo #(
  parameter int CHANNELS        = 4,
  parameter int ADDR_WIDTH      = 5,
  parameter int DATA_WIDTH      = 32,
  parameter int ALMOST_FULL_LVL = 28,
  parameter int CH_WIDTH        = $clog2(CHANNELS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CHANNELS-1:0]              clear,
  input  logic                             din_valid,
  input  logic [CH_WIDTH-1:0]              din_ch,
  input  logic [DATA_WIDTH-1:0]            din,
  output logic                             din_ready,
  input  logic [CH_WIDTH-1:0]              dout_ch,
  output logic                             dout_valid,
  output logic [DATA_WIDTH-1:0]            dout,
  input  logic                             dout_ready,
  output logic [CHANNELS*(ADDR_WIDTH+1)-1:0] item_count,
  output logic [CHANNELS-1:0]              full,
  output logic [CHANNELS-1:0]              empty,
  output logic [CHANNELS-1:0]              almost_full,
  output logic [CHANNELS*16-1:0]           ovf_count
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [CHANNELS*DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q [CHANNELS];
  logic [ADDR_WIDTH-1:0] wptr_d [CHANNELS];
  logic [ADDR_WIDTH-1:0] rptr_q [CHANNELS];
  logic [ADDR_WIDTH-1:0] rptr_d [CHANNELS];
  logic [CW-1:0]         count_q [CHANNELS];
  logic [CW-1:0]         count_d [CHANNELS];
  logic [CHANNELS-1:0]   full_q, empty_q, af_q, enq_c, deq_c;
  logic                  enq, deq;

  assign din_ready   = ~full_q[din_ch] & rst_n;
  assign dout_valid  = ~empty_q[dout_ch];
  assign enq         = din_valid & din_ready;
  assign deq         = dout_valid & dout_ready;
  assign dout        = mem[{dout_ch, rptr_q[dout_ch]}];
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt
    assign item_count[g*CW +: CW] = count_q[g];
  end

  // clear wins over any transfer on its channel
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      enq_c[c]   = enq && din_ch == CH_WIDTH'(c);
      deq_c[c]   = deq && dout_ch == CH_WIDTH'(c);
      wptr_d[c]  = clear[c] ? '0 : wptr_q[c] + ADDR_WIDTH'(enq_c[c]);
      rptr_d[c]  = clear[c] ? '0 : rptr_q[c] + ADDR_WIDTH'(deq_c[c]);
      count_d[c] = clear[c] ? '0 : count_q[c] + CW'(enq_c[c]) - CW'(deq_c[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr_q[c]  <= '0;
        rptr_q[c]  <= '0;
        count_q[c] <= '0;
      end
      full_q  <= '0;
      empty_q <= '1;
      af_q    <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        wptr_q[c]  <= wptr_d[c];
        rptr_q[c]  <= rptr_d[c];
        count_q[c] <= count_d[c];
        full_q[c]  <= count_d[c] == CW'(DEPTH);
        empty_q[c] <= count_d[c] == '0;
        af_q[c]    <= count_d[c] >= CW'(ALMOST_FULL_LVL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq && !clear[din_ch]) mem[{din_ch, wptr_q[din_ch]}] <= din;
  end

`ifdef SIMPLE_MULTI_FIFO_OVF_CNT_EN
  logic [15:0] ovf_q [CHANNELS];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) ovf_q[c] <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++)
        ovf_q[c] <= clear[c] ? '0 :
                    (din_valid && !din_ready && din_ch == CH_WIDTH'(c) && ovf_q[c] != 16'hFFFF) ? ovf_q[c] + 16'd1 :
                    ovf_q[c];
    end
  end
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ovf
    assign ovf_count[g*16 +: 16] = ovf_q[g];
  end
`else
  assign ovf_count = '0;
`endif
endmodule

// File: tb/tb_simple_multi_fifo.sv
// tb_simple_multi_fifo: scoreboard bench for simple_multi_fifo (defaults: 4 channels, depth 32).
module tb_simple_multi_fifo;
  logic        clk = 0, rst_n = 0;
  logic [3:0]  clear = '0;
  logic        din_valid = 0, dout_ready = 0;
  logic [1:0]  din_ch = '0, dout_ch = '0;
  logic [31:0] din = '0;
  logic        din_ready, dout_valid;
  logic [31:0] dout;
  logic [23:0] item_count;
  logic [3:0]  full, empty, almost_full;
  logic [63:0] ovf_count;
  logic [31:0] sb [4][$];
  int          passed = 0, total = 0;

  simple_multi_fifo dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .din_valid(din_valid), .din_ch(din_ch), .din(din),
    .din_ready(din_ready), .dout_ch(dout_ch), .dout_valid(dout_valid), .dout(dout),
    .dout_ready(dout_ready), .item_count(item_count), .full(full), .empty(empty),
    .almost_full(almost_full), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] cnt(input int c);
    return item_count[c*6 +: 6];
  endfunction

  function automatic logic [15:0] ovf(input int c);
    return ovf_count[c*16 +: 16];
  endfunction

  // drive one cycle from a negedge and mirror the expected transfers into the scoreboard
  task automatic step(input bit v, input logic [1:0] wc, input logic [31:0] d,
                      input bit r, input logic [1:0] rc, input logic [3:0] clr);
    bit e, q;
    din_valid = v; din_ch = wc; din = d; dout_ready = r; dout_ch = rc; clear = clr;
    e = v && sb[wc].size() < 32;
    q = r && sb[rc].size() > 0;
    if (q && !clr[rc]) void'(sb[rc].pop_front());
    if (e && !clr[wc]) sb[wc].push_back(d);
    for (int c = 0; c < 4; c++) if (clr[c]) sb[c].delete();
    @(posedge clk);
    @(negedge clk);
    din_valid = 0; dout_ready = 0; clear = '0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #1;
    total++; if (item_count !== 24'd0) $display("FAIL rst_count got %h exp 0", item_count); else passed++;
    total++; if (empty !== 4'b1111) $display("FAIL rst_empty got %b exp 1111", empty); else passed++;
    total++; if ({full, almost_full} !== 8'd0) $display("FAIL rst_flags got %b exp 0", {full, almost_full}); else passed++;
    total++; if (din_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", din_ready); else passed++;
    total++; if (ovf_count !== 64'd0) $display("FAIL rst_ovf got %h exp 0", ovf_count); else passed++;
    @(negedge clk);
    rst_n = 1;
    #1;
    total++; if (din_ready !== 1'b1) $display("FAIL rel_ready got %b exp 1", din_ready); else passed++;
    @(negedge clk);
    for (int i = 0; i < 7; i++) step(1, 2'd1, 32'h100 + i, 0, 2'd0, '0);
    total++; if (cnt(1) !== 6'd7) $display("FAIL ch1_cnt7 got %0d exp 7", cnt(1)); else passed++;
    din_ch = 2'd1;
    #2 rst_n = 0;
    for (int c = 0; c < 4; c++) sb[c].delete();
    #1;
    total++; if (item_count !== 24'd0) $display("FAIL mid_rst_count got %h exp 0", item_count); else passed++;
    total++; if (empty !== 4'b1111) $display("FAIL mid_rst_empty got %b exp 1111", empty); else passed++;
    total++; if (din_ready !== 1'b0) $display("FAIL mid_rst_ready got %b exp 0", din_ready); else passed++;
    @(negedge clk);
    rst_n = 1;
    #1;
    total++; if (din_ready !== 1'b1) $display("FAIL mid_rel_ready got %b exp 1", din_ready); else passed++;
    @(negedge clk);
  endtask

  task automatic test_fill_wrap;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 32; i++) begin
        step(1, 2'd2, 32'h2000 + p*256 + i, 0, 2'd0, '0);
        total++; if (almost_full[2] !== (i + 1 >= 28)) $display("FAIL af2 p%0d w%0d got %b exp %b", p, i + 1, almost_full[2], i + 1 >= 28); else passed++;
      end
      din_ch = 2'd2;
      #1;
      total++; if (full[2] !== 1'b1 || cnt(2) !== 6'd32) $display("FAIL full2 p%0d got full=%b cnt=%0d exp 1/32", p, full[2], cnt(2)); else passed++;
      total++; if (din_ready !== 1'b0) $display("FAIL full2_ready p%0d got %b exp 0", p, din_ready); else passed++;
      for (int i = 0; i < 32; i++) begin
        dout_ch = 2'd2;
        #1;
        total++; if (dout_valid !== 1'b1 || dout !== sb[2][0] || dout !== 32'(32'h2000 + p*256 + i)) $display("FAIL drain2 p%0d r%0d got v=%b d=%h exp 1/%h", p, i, dout_valid, dout, 32'h2000 + p*256 + i); else passed++;
        step(0, 2'd0, '0, 1, 2'd2, '0);
      end
      total++; if (empty[2] !== 1'b1 || cnt(2) !== 6'd0 || almost_full[2] !== 1'b0) $display("FAIL empty2 p%0d got e=%b cnt=%0d af=%b exp 1/0/0", p, empty[2], cnt(2), almost_full[2]); else passed++;
    end
  endtask

  task automatic test_isolation;
    for (int i = 0; i < 4; i++) begin
      step(1, 2'd0, 32'hA0 + i, 0, 2'd0, '0);
      step(1, 2'd3, 32'hD0 + i, 0, 2'd0, '0);
    end
    for (int i = 0; i < 4; i++) begin
      dout_ch = 2'd3;
      #1;
      total++; if (dout_valid !== 1'b1 || dout !== sb[3][0] || dout !== 32'(32'hD0 + i)) $display("FAIL iso3 r%0d got %h exp %h", i, dout, 32'hD0 + i); else passed++;
      step(0, 2'd0, '0, 1, 2'd3, '0);
    end
    total++; if (cnt(0) !== 6'd4 || cnt(3) !== 6'd0) $display("FAIL iso_cnt got c0=%0d c3=%0d exp 4/0", cnt(0), cnt(3)); else passed++;
    for (int i = 0; i < 4; i++) begin
      dout_ch = 2'd0;
      #1;
      total++; if (dout_valid !== 1'b1 || dout !== sb[0][0] || dout !== 32'(32'hA0 + i)) $display("FAIL iso0 r%0d got %h exp %h", i, dout, 32'hA0 + i); else passed++;
      step(0, 2'd0, '0, 1, 2'd0, '0);
    end
    dout_ch = 2'd3;
    #1;
    total++; if (dout_valid !== 1'b0) $display("FAIL iso3_empty got %b exp 0", dout_valid); else passed++;
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 4; i++) step(1, 2'd1, 32'h1100 + i, 0, 2'd0, '0);
    for (int i = 0; i < 10; i++) begin
      dout_ch = 2'd1;
      #1;
      total++; if (dout !== sb[1][0]) $display("FAIL sim1 c%0d got %h exp %h", i, dout, sb[1][0]); else passed++;
      step(1, 2'd1, 32'h1200 + i, 1, 2'd1, '0);
      total++; if (cnt(1) !== 6'd4) $display("FAIL sim1_cnt c%0d got %0d exp 4", i, cnt(1)); else passed++;
    end
    step(1, 2'd0, 32'h0BEE, 1, 2'd1, '0);
    total++; if (cnt(0) !== 6'd1 || cnt(1) !== 6'd3) $display("FAIL cross_cnt got c0=%0d c1=%0d exp 1/3", cnt(0), cnt(1)); else passed++;
    dout_ch = 2'd1;
    #1;
    total++; if (dout !== sb[1][0] || dout !== 32'h1207) $display("FAIL cross_head got %h exp 1207", dout); else passed++;
  endtask

  task automatic test_full_clear;
    for (int i = 1; i < 32; i++) step(1, 2'd0, 32'hF000 + i, 0, 2'd0, '0);
    din_valid = 1; din_ch = 2'd0; dout_ch = 2'd0; dout_ready = 1;
    #1;
    total++; if (din_ready !== 1'b0) $display("FAIL full_deq_ready got %b exp 0", din_ready); else passed++;
    step(1, 2'd0, 32'hDEAD, 1, 2'd0, '0);
    total++; if (din_ready !== 1'b1 || cnt(0) !== 6'd31) $display("FAIL after_deq got rdy=%b cnt=%0d exp 1/31", din_ready, cnt(0)); else passed++;
    step(1, 2'd0, 32'hBAD0, 0, 2'd0, 4'b0001);
    total++; if (cnt(0) !== 6'd0 || empty[0] !== 1'b1) $display("FAIL clr0 got cnt=%0d e=%b exp 0/1", cnt(0), empty[0]); else passed++;
    total++; if (cnt(1) !== 6'(sb[1].size()) || cnt(1) !== 6'd3) $display("FAIL clr_other got c1=%0d exp 3", cnt(1)); else passed++;
    step(1, 2'd0, 32'h0C0C, 0, 2'd0, '0);
    dout_ch = 2'd0;
    #1;
    total++; if (dout_valid !== 1'b1 || dout !== 32'h0C0C) $display("FAIL post_clr got v=%b d=%h exp 1/0c0c", dout_valid, dout); else passed++;
  endtask

  task automatic test_overflow;
    logic [15:0] exp_ovf;
    for (int i = 0; i < 32; i++) step(1, 2'd3, 32'h3300 + i, 0, 2'd0, '0);
    for (int i = 0; i < 5; i++) step(1, 2'd3, 32'hEEEE, 0, 2'd0, '0);
`ifdef SIMPLE_MULTI_FIFO_OVF_CNT_EN
    exp_ovf = 16'd5;
`else
    exp_ovf = 16'd0;
`endif
    total++; if (ovf(3) !== exp_ovf) $display("FAIL ovf3 got %0d exp %0d", ovf(3), exp_ovf); else passed++;
    total++; if (cnt(3) !== 6'd32) $display("FAIL ovf3_cnt got %0d exp 32", cnt(3)); else passed++;
    step(0, 2'd0, '0, 0, 2'd0, 4'b1000);
    total++; if (ovf(3) !== 16'd0 || cnt(3) !== 6'd0) $display("FAIL ovf3_clr got ovf=%0d cnt=%0d exp 0/0", ovf(3), cnt(3)); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_fill_wrap;
    test_isolation;
    test_simultaneous;
    test_full_clear;
    test_overflow;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
